// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - sram-like request/response bundle used by every arbiter port
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - 2:1 sram-like arbiter, one outstanding transaction, grant locked until data return
// ARB_RR_EN: alternate priority after each completion; default build is fixed data-first priority.
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  sram_like_arbiter_if.slave  instPort,
  sram_like_arbiter_if.slave  dataPort,
  sram_like_arbiter_if.master memPort,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic SEL_INST = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  state_t            fsm;
  logic              owner;
  logic              prio;
  logic              sel;
  logic              grant;
  logic              reqOut;
  logic              bridgeReq;
  logic [ADDR_W-1:0] grantAddr;
  logic [DATA_W-1:0] grantWdata;

  always_comb begin
    sel        = prio ? ~instPort.req : dataPort.req;
    grant      = (fsm == IDLE) ? sel : owner;
    grantAddr  = grant ? dataPort.addr  : instPort.addr;
    grantWdata = grant ? dataPort.wdata : instPort.wdata;
    case (fsm)
      IDLE:    reqOut = instPort.req | dataPort.req;
      ADDR:    reqOut = grant ? dataPort.req : instPort.req;
      default: reqOut = 1'b0;
    endcase
    // requests must not leak to the bridge while reset is held
    bridgeReq = reqOut & ~rst;
  end

  always_comb begin
    memPort.req   = bridgeReq;
    memPort.wr    = grant ? dataPort.wr   : instPort.wr;
    memPort.size  = grant ? dataPort.size : instPort.size;
    memPort.addr  = grantAddr;
    memPort.wdata = grantWdata;

    instPort.addr_ok = memPort.addr_ok & bridgeReq & (grant == SEL_INST);
    dataPort.addr_ok = memPort.addr_ok & bridgeReq & (grant == SEL_DATA);
    instPort.data_ok = memPort.data_ok & (fsm == DATA) & (owner == SEL_INST);
    dataPort.data_ok = memPort.data_ok & (fsm == DATA) & (owner == SEL_DATA);
    instPort.rdata   = memPort.rdata;
    dataPort.rdata   = memPort.rdata;
    busy             = (fsm != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm   <= IDLE;
      owner <= SEL_INST;
      prio  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (reqOut) begin
            owner <= sel;
            fsm   <= memPort.addr_ok ? DATA : ADDR;
          end
        end
        ADDR: begin
          if (memPort.addr_ok) fsm <= DATA;
        end
        DATA: begin
          if (memPort.data_ok) begin
            fsm <= IDLE;
`ifdef ARB_RR_EN
            // hand priority to the requester that did not just finish
            prio <= owner;
`endif
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - randomized scoreboard bench for sram_like_arbiter
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) instIf ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dataIf ();
  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) memIf ();

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .instPort (instIf),
    .dataPort (dataIf),
    .memPort  (memIf),
    .busy     (busy)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // one expected cycle of DUT behaviour; index 0 = inst port, 1 = data port
  typedef struct packed {
    logic        busy;
    logic        mReq;
    req_t        fld;
    logic [1:0]  aOk;
    logic [1:0]  dOk;
    logic [31:0] rdata;
  } rec_t;

  // transaction-level reference: who owns the bus, whether its address was taken, who is favoured
  int   cur      = -1;
  bit   accepted = 1'b0;
  int   favoured = 1;
  bit   pend [2];
  req_t rq   [2];
  rec_t expQ [$];
  rec_t monE;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t randReq();
    req_t r;
    r.wr    = 1'($urandom_range(1));
    r.size  = 2'($urandom_range(2));
    r.addr  = $urandom & 32'hFFFF_FFFC;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic driveReqs();
    instIf.req   = pend[0];
    instIf.wr    = rq[0].wr;
    instIf.size  = rq[0].size;
    instIf.addr  = rq[0].addr;
    instIf.wdata = rq[0].wdata;
    dataIf.req   = pend[1];
    dataIf.wr    = rq[1].wr;
    dataIf.size  = rq[1].size;
    dataIf.addr  = rq[1].addr;
    dataIf.wdata = rq[1].wdata;
  endtask

  // pI/pD: percent chance an idle requester issues; pA/pDo: percent chance of addr_ok/data_ok this cycle
  task automatic step(input int pI, input int pD, input int pA, input int pDo, input logic [31:0] rd);
    rec_t r;
    bit   aOk;
    bit   dOk;
    int   w;
    if (!pend[0] && int'($urandom_range(99)) < pI) begin pend[0] = 1'b1; rq[0] = randReq(); end
    if (!pend[1] && int'($urandom_range(99)) < pD) begin pend[1] = 1'b1; rq[1] = randReq(); end
    aOk = int'($urandom_range(99)) < pA;
    dOk = int'($urandom_range(99)) < pDo;
    driveReqs();
    memIf.addr_ok = aOk;
    memIf.data_ok = dOk;
    memIf.rdata   = rd;

    r = '0;
    r.busy = (cur >= 0);
    if (cur < 0) begin
      if (pend[0] || pend[1]) begin
        w        = pend[favoured] ? favoured : 1 - favoured;
        r.mReq   = 1'b1;
        r.fld    = rq[w];
        cur      = w;
        accepted = 1'b0;
        if (aOk) begin r.aOk[w] = 1'b1; accepted = 1'b1; pend[w] = 1'b0; end
      end
    end else if (!accepted) begin
      r.mReq = 1'b1;
      r.fld  = rq[cur];
      if (aOk) begin r.aOk[cur] = 1'b1; accepted = 1'b1; pend[cur] = 1'b0; end
    end else if (dOk) begin
      r.dOk[cur] = 1'b1;
      r.rdata    = rd;
`ifdef ARB_RR_EN
      favoured = 1 - cur;
`endif
      cur = -1;
    end
    expQ.push_back(r);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk("busy", 64'(busy), 64'(monE.busy));
      chk("m_req", 64'(memIf.req), 64'(monE.mReq));
      if (monE.mReq) begin
        chk("m_wr_size_addr", 64'({memIf.wr, memIf.size, memIf.addr}),
            64'({monE.fld.wr, monE.fld.size, monE.fld.addr}));
        chk("m_wdata", 64'(memIf.wdata), 64'(monE.fld.wdata));
      end
      chk("i_addr_ok", 64'(instIf.addr_ok), 64'(monE.aOk[0]));
      chk("d_addr_ok", 64'(dataIf.addr_ok), 64'(monE.aOk[1]));
      chk("i_data_ok", 64'(instIf.data_ok), 64'(monE.dOk[0]));
      chk("d_data_ok", 64'(dataIf.data_ok), 64'(monE.dOk[1]));
      if (monE.dOk[0]) chk("i_rdata", 64'(instIf.rdata), 64'(monE.rdata));
      if (monE.dOk[1]) chk("d_rdata", 64'(dataIf.rdata), 64'(monE.rdata));
    end
  end

  initial begin
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    rq[0]   = '0;
    rq[1]   = '0;
    driveReqs();
    memIf.addr_ok = 1'b0;
    memIf.data_ok = 1'b0;
    memIf.rdata   = '0;
    repeat (2) @(posedge clk);
    #1;

    // outputs held quiet under reset even with everything asserted
    instIf.req = 1'b1;
    dataIf.req = 1'b1;
    memIf.addr_ok = 1'b1;
    memIf.data_ok = 1'b1;
    #1;
    chk("rst m_req", 64'(memIf.req), 64'd0);
    chk("rst i_addr_ok", 64'(instIf.addr_ok), 64'd0);
    chk("rst d_addr_ok", 64'(dataIf.addr_ok), 64'd0);
    chk("rst i_data_ok", 64'(instIf.data_ok), 64'd0);
    chk("rst d_data_ok", 64'(dataIf.data_ok), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    driveReqs();
    memIf.addr_ok = 1'b0;
    memIf.data_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single fetch: zero-wait accept, data 3 cycles later
    rq[0]   = '{1'b0, 2'd2, 32'hBFC0_0000, 32'h0};
    pend[0] = 1'b1;
    step(0, 0, 100, 0, $urandom);
    step(0, 0, 0, 0, $urandom);
    step(0, 0, 0, 0, $urandom);
    step(0, 0, 0, 100, 32'h3C08_0001);
    step(0, 0, 0, 0, $urandom);

    // stray data_ok in IDLE and ADDR
    step(0, 0, 0, 100, $urandom);
    rq[0]   = randReq();
    pend[0] = 1'b1;
    step(0, 0, 0, 100, $urandom);
    step(0, 0, 0, 100, $urandom);
    step(0, 0, 100, 0, $urandom);
    step(0, 0, 0, 100, $urandom);

    // grant lock: inst waits for addr_ok while data request arrives
    rq[0]   = randReq();
    pend[0] = 1'b1;
    step(0, 0, 0, 0, $urandom);
    rq[1]   = randReq();
    pend[1] = 1'b1;
    step(0, 0, 0, 0, $urandom);
    step(0, 0, 100, 0, $urandom);
    step(0, 0, 0, 100, $urandom);
    step(0, 0, 100, 0, $urandom);
    step(0, 0, 0, 100, $urandom);

    // both requesters continuously active
    rq[1]   = '{1'b1, 2'd2, 32'h8000_1000, 32'h1234_5678};
    pend[1] = 1'b1;
    rq[0]   = randReq();
    pend[0] = 1'b1;
    for (int i = 0; i < 12; i++) step(100, 100, 100, 100, $urandom);

    // randomized traffic
    for (int i = 0; i < 1500; i++) step(40, 40, 60, 50, $urandom);

    // drain, then put a data transaction into DATA and reset mid-flight
    for (int i = 0; i < 50 && (cur >= 0 || pend[0] || pend[1]); i++) step(0, 0, 100, 100, $urandom);
    chk("drained", 64'(cur >= 0 || pend[0] || pend[1]), 64'd0);
    rq[1]   = randReq();
    pend[1] = 1'b1;
    step(0, 0, 100, 0, $urandom);
    rq[0]   = '{1'b0, 2'd2, 32'hBFC0_0040, 32'h0};
    pend[0] = 1'b1;
    driveReqs();
    memIf.addr_ok = 1'b1;
    memIf.data_ok = 1'b1;
    #1;
    chk("pre_rst d_data_ok", 64'(dataIf.data_ok), 64'(cur == 1 && accepted));
    rst = 1'b1;
    #1;
    chk("midrst m_req", 64'(memIf.req), 64'd0);
    chk("midrst i_addr_ok", 64'(instIf.addr_ok), 64'd0);
    chk("midrst d_addr_ok", 64'(dataIf.addr_ok), 64'd0);
    chk("midrst i_data_ok", 64'(instIf.data_ok), 64'd0);
    chk("midrst d_data_ok", 64'(dataIf.data_ok), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("midrst held busy", 64'(busy), 64'd0);
    chk("midrst held m_req", 64'(memIf.req), 64'd0);
    #2;
    rst      = 1'b0;
    cur      = -1;
    accepted = 1'b0;
    favoured = 1;
    step(0, 0, 100, 0, $urandom);
    step(0, 0, 0, 0, $urandom);
    step(0, 0, 0, 100, $urandom);
    step(0, 0, 0, 0, $urandom);

    @(negedge clk);
    #1;
    chk("queue_empty", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
